// File: rtl/s1494_pkg.sv
// Shared definitions for the s1494 sequencing controller.
// - Default primary-input and state widths of the s1494 benchmark.
// - The controller FSM state encoding.
// - Bit offsets of the fields packed into cone_in.
package s1494_pkg;

  localparam int unsigned NpiDefault = 7;  // v0..v6
  localparam int unsigned NstDefault = 6;  // v7..v12

  // cone_in = {pi_l, state}: state sits in the LSBs and pi above it.
  localparam int unsigned ConeInStLsb = 0;
  localparam int unsigned ConeInPiLsb = NstDefault;

  typedef enum logic [1:0] {
    StIdle,
    StEval,
    StDone
  } fsm_e;

endpackage

// File: rtl/s1494_seq_ctrl_if.sv
// Bus bundle between the s1494 sequencing controller and its environment.
// Signals:
//   in_valid/in_ready/pi_vec/CLR   step request from the stimulus source
//   cone_sel/cone_in/cone_out      shared cone evaluator access
//   out_valid/out_ready/out_state  committed state presented downstream
// Modports: master = controller side, slave = stimulus/cone/consumer side.
interface s1494_seq_ctrl_if
  import s1494_pkg::*;
#(
  parameter int unsigned NPI = NpiDefault,
  parameter int unsigned NST = NstDefault
);

  logic                    in_valid;
  logic                    in_ready;
  logic [NPI-1:0]          pi_vec;
  logic                    CLR;
  logic [$clog2(NST)-1:0]  cone_sel;
  logic [NPI+NST-1:0]      cone_in;
  logic                    cone_out;
  logic                    out_valid;
  logic                    out_ready;
  logic [NST-1:0]          out_state;

  modport master (
    input  in_valid, pi_vec, CLR, cone_out, out_ready,
    output in_ready, cone_sel, cone_in, out_valid, out_state
  );

  modport slave (
    output in_valid, pi_vec, CLR, cone_out, out_ready,
    input  in_ready, cone_sel, cone_in, out_valid, out_state
  );

endinterface

// File: rtl/s1494_lat_cnt.sv
// Cone latency slot counter for the s1494 sequencing controller.
// Counts down from ConeLat-1 while enabled and raises sample_o on the last
// cycle of each slot, then reloads for the next slot.
// Ports:
//   clk_i     clock
//   rst_i     asynchronous active-high reset
//   load_i    restart the slot count (start of a step)
//   en_i      a slot is in progress
//   sample_o  last cycle of the current slot; cone_out is valid now
module s1494_lat_cnt #(
  parameter int unsigned ConeLat = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  input  logic en_i,
  output logic sample_o
);

  localparam int unsigned CntW = (ConeLat > 1) ? $clog2(ConeLat) : 1;
  localparam logic [CntW-1:0] Reload = CntW'(ConeLat - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign sample_o = en_i && (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q;
    if (load_i || sample_o) begin
      cnt_d = Reload;
    end else if (en_i) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= Reload;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/s1494_seq_ctrl.sv
// s1494 sequencing controller: rebuilds the benchmark's sequential behaviour
// from its single-output combinational cones. One step per accepted pi_vec:
// each next-state bit is evaluated in turn on a shared cone evaluator, then
// the whole state is committed and presented downstream.
// Ports:
//   CK        clock, rising edge
//   RST       asynchronous active-high reset
//   step_cnt  completed-step counter (only with S1494_STEP_CNT_EN defined)
//   bus       s1494_seq_ctrl_if.master: step handshake, cone access, output
// Build option: define S1494_STEP_CNT_EN to add the 16-bit step_cnt output.
module s1494_seq_ctrl
  import s1494_pkg::*;
#(
  parameter int unsigned NPI      = NpiDefault,
  parameter int unsigned NST      = NstDefault,
  parameter int unsigned CONE_LAT = 1
) (
  input  logic               CK,
  input  logic               RST,
`ifdef S1494_STEP_CNT_EN
  output logic [15:0]        step_cnt,
`endif
  s1494_seq_ctrl_if.master   bus
);

  localparam int unsigned KW = $clog2(NST);
  localparam logic [KW-1:0] KLast = KW'(NST - 1);

  fsm_e           fsm_q, fsm_d;
  logic [NPI-1:0] pi_l_q, pi_l_d;
  logic [NST-1:0] state_q, state_d;
  logic [NST-1:0] shadow_q, shadow_d;
  logic [KW-1:0]  k_q, k_d;

  logic lat_load;
  logic lat_en;
  logic lat_sample;

  s1494_lat_cnt #(
    .ConeLat (CONE_LAT)
  ) u_lat_cnt (
    .clk_i    (CK),
    .rst_i    (RST),
    .load_i   (lat_load),
    .en_i     (lat_en),
    .sample_o (lat_sample)
  );

  always_comb begin
    fsm_d    = fsm_q;
    pi_l_d   = pi_l_q;
    state_d  = state_q;
    shadow_d = shadow_q;
    k_d      = k_q;
    lat_load = 1'b0;
    lat_en   = 1'b0;
    unique case (fsm_q)
      StIdle: begin
        if (bus.in_valid) begin
          pi_l_d = bus.pi_vec;
          if (bus.CLR) begin
            fsm_d    = StEval;
            k_d      = '0;
            lat_load = 1'b1;
          end else begin
            // Active-low clear: skip evaluation entirely.
            fsm_d   = StDone;
            state_d = '0;
          end
        end
      end
      StEval: begin
        lat_en = 1'b1;
        if (lat_sample) begin
          shadow_d[k_q] = bus.cone_out;
          if (k_q == KLast) begin
            // Last bit is taken live so the commit needs no extra cycle.
            state_d        = shadow_q;
            state_d[KLast] = bus.cone_out;
            k_d            = '0;
            fsm_d          = StDone;
          end else begin
            k_d = k_q + KW'(1);
          end
        end
      end
      StDone: begin
        if (bus.out_ready) begin
          fsm_d = StIdle;
        end
      end
      default: fsm_d = StIdle;
    endcase
  end

  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      fsm_q    <= StIdle;
      pi_l_q   <= '0;
      state_q  <= '0;
      shadow_q <= '0;
      k_q      <= '0;
    end else begin
      fsm_q    <= fsm_d;
      pi_l_q   <= pi_l_d;
      state_q  <= state_d;
      shadow_q <= shadow_d;
      k_q      <= k_d;
    end
  end

  // Outputs depend on registered state only.
  assign bus.in_ready  = (fsm_q == StIdle);
  assign bus.out_valid = (fsm_q == StDone);
  assign bus.cone_sel  = k_q;
  assign bus.cone_in   = {pi_l_q, state_q};
  assign bus.out_state = state_q;

`ifdef S1494_STEP_CNT_EN
  logic [15:0] step_cnt_q, step_cnt_d;

  always_comb begin
    step_cnt_d = step_cnt_q;
    if ((fsm_q == StDone) && bus.out_ready) begin
      step_cnt_d = step_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      step_cnt_q <= '0;
    end else begin
      step_cnt_q <= step_cnt_d;
    end
  end

  assign step_cnt = step_cnt_q;
`endif

endmodule

// File: tb/tb_s1494_seq_ctrl.sv
// Testbench for s1494_seq_ctrl: instance A uses CONE_LAT=1 with a
// combinational cone model, instance B uses CONE_LAT=3 with a two-stage
// pipelined cone model. Cone model: cone_out = pi_l[k] ^ state[k].
module tb_s1494_seq_ctrl;
  import s1494_pkg::*;

  localparam int unsigned NPI = 7;
  localparam int unsigned NST = 6;

  logic CK = 1'b0;
  logic RST;
  always #5 CK = ~CK;

  int checks = 0;
  int errors = 0;

  s1494_seq_ctrl_if #(.NPI(NPI), .NST(NST)) ifa ();
  s1494_seq_ctrl_if #(.NPI(NPI), .NST(NST)) ifb ();

`ifdef S1494_STEP_CNT_EN
  logic [15:0] step_cnt_a;
  logic [15:0] step_cnt_b;
`endif

  s1494_seq_ctrl #(.NPI(NPI), .NST(NST), .CONE_LAT(1)) u_dut_a (
    .CK       (CK),
    .RST      (RST),
`ifdef S1494_STEP_CNT_EN
    .step_cnt (step_cnt_a),
`endif
    .bus      (ifa)
  );

  s1494_seq_ctrl #(.NPI(NPI), .NST(NST), .CONE_LAT(3)) u_dut_b (
    .CK       (CK),
    .RST      (RST),
`ifdef S1494_STEP_CNT_EN
    .step_cnt (step_cnt_b),
`endif
    .bus      (ifb)
  );

  function automatic logic cone_f(input logic [NPI+NST-1:0] ci, input logic [2:0] sel);
    if (int'(sel) >= int'(NST)) return 1'b0;
    return ci[ConeInPiLsb + int'(sel)] ^ ci[ConeInStLsb + int'(sel)];
  endfunction

  assign ifa.cone_out = cone_f(ifa.cone_in, ifa.cone_sel);

  logic [1:0] pipe_b;
  always_ff @(posedge CK) pipe_b <= {pipe_b[0], cone_f(ifb.cone_in, ifb.cone_sel)};
  assign ifb.cone_out = pipe_b[1];

  function automatic logic get_ov(input bit sel);
    return sel ? ifb.out_valid : ifa.out_valid;
  endfunction
  function automatic logic get_ir(input bit sel);
    return sel ? ifb.in_ready : ifa.in_ready;
  endfunction
  function automatic logic [2:0] get_cs(input bit sel);
    return sel ? ifb.cone_sel : ifa.cone_sel;
  endfunction
  function automatic logic [12:0] get_ci(input bit sel);
    return sel ? ifb.cone_in : ifa.cone_in;
  endfunction
  function automatic logic [5:0] get_st(input bit sel);
    return sel ? ifb.out_state : ifa.out_state;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_in(input bit sel, input logic v, input logic [6:0] pi, input logic clr);
    if (sel) begin
      ifb.in_valid = v; ifb.pi_vec = pi; ifb.CLR = clr;
    end else begin
      ifa.in_valid = v; ifa.pi_vec = pi; ifa.CLR = clr;
    end
  endtask

  task automatic drive_or(input bit sel, input logic r);
    if (sel) ifb.out_ready = r;
    else     ifa.out_ready = r;
  endtask

  task automatic chk_idle_reset(input bit sel, input string tag);
    chk($sformatf("%s_out_valid", tag), 32'(get_ov(sel)), 32'd0);
    chk($sformatf("%s_in_ready", tag), 32'(get_ir(sel)), 32'd1);
    chk($sformatf("%s_cone_sel", tag), 32'(get_cs(sel)), 32'd0);
    chk($sformatf("%s_cone_in", tag), 32'(get_ci(sel)), 32'd0);
    chk($sformatf("%s_out_state", tag), 32'(get_st(sel)), 32'd0);
  endtask

  // Called at a falling edge with the DUT idle; returns with the DUT in DONE.
  task automatic do_step(input bit sel, input logic [6:0] pi, input logic clr,
                         input logic [5:0] pre, input int exp_lat,
                         input logic [5:0] exp_st, input string tag);
    int lat;
    int seq_bad;
    int lat_per;
    lat_per = sel ? 3 : 1;
    chk($sformatf("%s_in_ready", tag), 32'(get_ir(sel)), 32'd1);
    drive_in(sel, 1'b1, pi, clr);
    @(negedge CK);
    // Busy-time input changes must be ignored.
    drive_in(sel, 1'b0, ~pi, ~clr);
    lat = 1;
    seq_bad = 0;
    while (!get_ov(sel) && lat < 100) begin
      if (get_cs(sel) != 3'((lat - 1) / lat_per) || get_ci(sel) != {pi, pre} || get_ir(sel))
        seq_bad++;
      @(negedge CK);
      lat++;
    end
    chk($sformatf("%s_latency", tag), 32'(lat), 32'(exp_lat));
    chk($sformatf("%s_eval_seq", tag), 32'(seq_bad), 32'd0);
    chk($sformatf("%s_out_state", tag), 32'(get_st(sel)), 32'(exp_st));
    chk($sformatf("%s_done_cone_sel", tag), 32'(get_cs(sel)), 32'd0);
  endtask

  task automatic release_step(input bit sel);
    drive_or(sel, 1'b1);
    @(negedge CK);
    drive_or(sel, 1'b0);
  endtask

  typedef struct {
    bit         sel;
    logic [6:0] pi;
    logic       clr;
    logic [5:0] exp_st;
    int         exp_lat;
  } vec_t;

  vec_t vecs[11];

  initial begin
    logic [5:0] prev;

    // Instance A, CONE_LAT=1: latency 7 normal, 1 clear.
    vecs[0]  = '{1'b0, 7'h15, 1'b1, 6'h15, 7};
    vecs[1]  = '{1'b0, 7'h3F, 1'b1, 6'h2A, 7};
    vecs[2]  = '{1'b0, 7'h00, 1'b0, 6'h00, 1};
    vecs[3]  = '{1'b0, 7'h7F, 1'b1, 6'h3F, 7};
    vecs[4]  = '{1'b0, 7'h41, 1'b1, 6'h3E, 7};
    vecs[5]  = '{1'b0, 7'h2C, 1'b1, 6'h12, 7};
    // Instance B, CONE_LAT=3: latency 19 normal, 1 clear.
    vecs[6]  = '{1'b1, 7'h15, 1'b1, 6'h15, 19};
    vecs[7]  = '{1'b1, 7'h3F, 1'b1, 6'h2A, 19};
    vecs[8]  = '{1'b1, 7'h00, 1'b0, 6'h00, 1};
    vecs[9]  = '{1'b1, 7'h7F, 1'b1, 6'h3F, 19};
    vecs[10] = '{1'b1, 7'h41, 1'b1, 6'h3E, 19};

    RST = 1'b1;
    drive_in(1'b0, 1'b0, 7'h00, 1'b0);
    drive_in(1'b1, 1'b0, 7'h00, 1'b0);
    drive_or(1'b0, 1'b0);
    drive_or(1'b1, 1'b0);
    repeat (2) @(negedge CK);
    chk_idle_reset(1'b0, "rst_a");
    chk_idle_reset(1'b1, "rst_b");
    RST = 1'b0;
    @(negedge CK);

    prev = 6'h00;
    for (int i = 0; i < 6; i++) begin
      do_step(vecs[i].sel, vecs[i].pi, vecs[i].clr, prev, vecs[i].exp_lat,
              vecs[i].exp_st, $sformatf("vec%0d", i));
      release_step(vecs[i].sel);
      prev = vecs[i].exp_st;
    end

    // Back-pressure: result holds and a new request is refused.
    do_step(1'b0, 7'h0F, 1'b1, 6'h12, 7, 6'h1D, "hold");
    for (int c = 0; c < 10; c++) begin
      drive_in(1'b0, (c == 4), 7'h00, 1'b0);
      @(negedge CK);
      chk($sformatf("hold%0d_out_valid", c), 32'(get_ov(1'b0)), 32'd1);
      chk($sformatf("hold%0d_out_state", c), 32'(get_st(1'b0)), 32'h1D);
      chk($sformatf("hold%0d_in_ready", c), 32'(get_ir(1'b0)), 32'd0);
    end
    drive_in(1'b0, 1'b0, 7'h00, 1'b0);
    release_step(1'b0);
    chk("post_hold_out_valid", 32'(get_ov(1'b0)), 32'd0);
    chk("post_hold_in_ready", 32'(get_ir(1'b0)), 32'd1);
    chk("post_hold_out_state", 32'(get_st(1'b0)), 32'h1D);

    // Reset on the third EVAL cycle aborts the step.
    drive_in(1'b0, 1'b1, 7'h33, 1'b1);
    @(negedge CK);
    drive_in(1'b0, 1'b0, 7'h00, 1'b0);
    repeat (2) @(negedge CK);
    chk("midrst_pre_cone_sel", 32'(get_cs(1'b0)), 32'd2);
    RST = 1'b1;
    #1;
    chk_idle_reset(1'b0, "midrst_a");
    @(negedge CK);
    chk_idle_reset(1'b0, "midrst_hold_a");
    RST = 1'b0;
    @(negedge CK);
    do_step(1'b0, 7'h15, 1'b1, 6'h00, 7, 6'h15, "cold");
    release_step(1'b0);

    prev = 6'h00;
    for (int i = 6; i < 11; i++) begin
      do_step(vecs[i].sel, vecs[i].pi, vecs[i].clr, prev, vecs[i].exp_lat,
              vecs[i].exp_st, $sformatf("vec%0d", i));
      release_step(vecs[i].sel);
      prev = vecs[i].exp_st;
    end

`ifdef S1494_STEP_CNT_EN
    chk("step_cnt_a", 32'(step_cnt_a), 32'd1);
    chk("step_cnt_b", 32'(step_cnt_b), 32'd5);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/s1494_seq_ctrl.md
# s1494_seq_ctrl

Sequencing controller that rebuilds the s1494 benchmark's sequential behaviour on top of its single-output combinational cones.
- Holds the NST-bit state register and accepts one primary-input vector per step over a valid/ready handshake.
- Time-multiplexes one shared cone evaluator, one next-state bit per slot, then commits the new state and presents it downstream.
- Sits between the stimulus source and the cone bank in the benchmark harness.

## Interface
Parameters:
- NPI, 7, primary-input width (v0..v6)
- NST, 6, state width (v7..v12)
- CONE_LAT, 1, cycles from cone_sel/cone_in change to valid cone_out (≥1)

Ports:
- CK  in  1  clock; all state on rising edge
- RST  in  1  reset, asynchronous, active-high
- in_valid  in  1  pi_vec/CLR valid
- in_ready  out  1  block can accept a step
- pi_vec  in  NPI  primary inputs for this step
- CLR  in  1  active-low clear, sampled with pi_vec
- cone_sel  out  $clog2(NST)  index of the cone being evaluated
- cone_in  out  NPI+NST  {latched pi_vec, state}, pi in the MSBs
- cone_out  in  1  result from the selected cone
- out_valid  out  1  out_state holds a committed state
- out_ready  in  1  consumer accepts out_state
- out_state  out  NST  committed state register

## Operation
FSM states: IDLE, EVAL, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready, latch pi_vec and CLR.
  - If CLR=1, go to EVAL with k=0 and the latency counter at 0.
  - If CLR=0, go to DONE with state forced to 0; no cones are evaluated.
- EVAL:
  - cone_sel=k and cone_in={pi_l, state} are held for CONE_LAT cycles.
  - On the last of those cycles, cone_out is written into shadow[k].
  - If k<NST-1: k++ and stay in EVAL.
  - If k=NST-1: state<=shadow with the final bit taken live from cone_out, then go to DONE.
- DONE:
  - out_valid=1 and out_state=state.
  - On out_ready, go to IDLE.
- The state register changes only on a commit or a clear. cone_in always reflects the pre-step state during EVAL.
- Inputs are ignored while busy: in_ready=0 in EVAL and DONE, and pi_vec changes have no effect.

## Timing
- Reset values:
  - FSM=IDLE, state=0, shadow=0, k=0
  - out_valid=0, in_ready=1, cone_sel=0
  - cone_in={0,0}
- in_ready and out_valid are decoded from the FSM state only. No combinational path runs from in_valid/out_ready to any output.
- Latency from the accept edge to out_valid=1:
  - normal step: NST·CONE_LAT+1 cycles (7 with the defaults)
  - CLR=0 step: 1 cycle
- Throughput: at least one IDLE cycle between steps; the defaults give one step per 8 cycles with out_ready tied high.
- out_ready=1 with out_valid=0 has no effect.
- out_valid stays high and out_state stays stable until out_ready is seen.
- Reset mid-EVAL or mid-DONE: the step is aborted immediately, shadow is discarded and state returns to 0.
- cone_out is don't-care outside sample cycles.

## Configuration
- S1494_STEP_CNT_EN defined:
  - Adds output step_cnt (16 bits, reset 0).
  - Increments once per DONE→IDLE transition and wraps 0xFFFF→0.
  - Both CLR steps and normal steps are counted.
- S1494_STEP_CNT_EN undefined: the port and counter are absent; all other behaviour is identical.

## Structure
- Shared package s1494_pkg:
  - FSM state enum (IDLE, EVAL, DONE)
  - NPI/NST default constants
  - cone_in field offsets
- One sub-module, s1494_lat_cnt: the CONE_LAT down-counter, which raises a sample strobe on the last cycle of each slot.
- The cone bank itself is outside this block.

## Test plan
Bench cone model: cone_out = pi_l[k] ^ state[k], delayed by CONE_LAT.
- From reset, step pi_vec=7'h15, CLR=1, out_ready=1:
  - out_valid rises 7 cycles after accept
  - out_state=6'h15
  - cone_sel sequence 0,1,2,3,4,5, one cycle each
- Second step with pi_vec=7'h3F: out_state=6'h15^6'h3F=6'h2A.
- CLR=0 step while state=6'h2A:
  - out_valid rises 1 cycle after accept with out_state=0
  - cone_sel stays 0
- Hold out_ready=0 for 10 cycles in DONE:
  - out_valid stays 1, out_state is stable, in_ready=0
  - a new in_valid pulse is not accepted
- Assert RST on the 3rd EVAL cycle:
  - FSM goes to IDLE, state=0, out_valid=0, in_ready=1 while RST is high
  - the next step behaves as if from cold reset
- CONE_LAT=3: each cone_sel value is held 3 cycles and latency is 19 cycles. With S1494_STEP_CNT_EN, step_cnt reads 5 after 5 steps, and wraps to 0 after 65536 steps.
